// File: rtl/regfile_writeback_queue_pkg.sv
// Shared constants and payload type for the register-file write path.
package regfile_writeback_queue_pkg;

    localparam int unsigned REG_ADDR_W = 4;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned DEPTH      = 4;
    localparam int unsigned PTR_W      = $clog2(DEPTH);
    localparam int unsigned CNT_W      = PTR_W + 1;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] wreg;
        logic [DATA_W-1:0]     data;
    } wb_entry_t;

endpackage

// File: rtl/regfile_writeback_queue_wb_fifo.sv
// Circular result buffer: two ordered pushes and one pop per cycle,
// per-entry valid bits and a parallel register-index compare for hazard checks.
module regfile_writeback_queue_wb_fifo
    import regfile_writeback_queue_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  push_a,
    input  wb_entry_t             entry_a,
    input  logic                  push_b,
    input  wb_entry_t             entry_b,
    input  logic                  pop,
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    output wb_entry_t             head_c,
    output logic [CNT_W-1:0]      count,
    output logic [DEPTH-1:0]      rs1_match_c,
    output logic [DEPTH-1:0]      rs2_match_c
);

    wb_entry_t          mem_q [DEPTH];
    logic [DEPTH-1:0]   valid_q;
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [PTR_W-1:0]   wr_ptr_b;
    logic [1:0]         n_push;

    // A push from the second producer lands behind the first one, if any.
    assign wr_ptr_b = wr_ptr_q + PTR_W'(push_a);
    assign n_push   = 2'(push_a) + 2'(push_b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count    <= '0;
        end else if (flush) begin
            valid_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count    <= '0;
        end else begin
            if (push_a) valid_q[wr_ptr_q] <= 1'b1;
            if (push_b) valid_q[wr_ptr_b] <= 1'b1;
            if (pop)    valid_q[rd_ptr_q] <= 1'b0;
            wr_ptr_q <= wr_ptr_q + PTR_W'(n_push);
            rd_ptr_q <= rd_ptr_q + PTR_W'(pop);
            count    <= count + CNT_W'(n_push) - CNT_W'(pop);
        end
    end

    // Payload storage needs no reset; valid bits qualify every read.
    always_ff @(posedge clk) begin
        if (push_a) mem_q[wr_ptr_q] <= entry_a;
        if (push_b) mem_q[wr_ptr_b] <= entry_b;
    end

    always_comb begin
        head_c      = mem_q[rd_ptr_q];
        rs1_match_c = '0;
        rs2_match_c = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            rs1_match_c[i] = valid_q[i] && (mem_q[i].wreg == rs1);
            rs2_match_c[i] = valid_q[i] && (mem_q[i].wreg == rs2);
        end
    end

endmodule

// File: rtl/regfile_writeback_queue.sv
// Write-back arbiter for the register file: accepts ALU and load results,
// queues them in order and issues one register write per cycle.
module regfile_writeback_queue
    import regfile_writeback_queue_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_reg,
    input  logic [DATA_W-1:0]     alu_data,
    output logic                  alu_ready,
    input  logic                  mem_valid,
    input  logic [REG_ADDR_W-1:0] mem_reg,
    input  logic [DATA_W-1:0]     mem_data,
    output logic                  mem_ready,
    input  logic                  flush,
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    output logic                  rs1_pending,
    output logic                  rs2_pending,
    output logic                  wb_regwrite,
    output logic [REG_ADDR_W-1:0] wb_reg,
    output logic [DATA_W-1:0]     wb_data
);

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] free_c;
    logic [DEPTH-1:0] rs1_match_c;
    logic [DEPTH-1:0] rs2_match_c;
    wb_entry_t        head_c;
    wb_entry_t        entry_a;
    wb_entry_t        entry_b;
    logic             push_a_c;
    logic             push_b_c;
    logic             pop_c;

    // ALU wins the last free slot; the load needs room left over after it.
    assign free_c    = CNT_W'(DEPTH) - count;
    assign alu_ready = !flush && (free_c >= CNT_W'(1));
    assign mem_ready = !flush && ((free_c >= CNT_W'(2)) ||
                                  ((free_c == CNT_W'(1)) && !alu_valid));

    // Writes to r0 complete the handshake but are dropped.
    assign push_a_c = alu_valid && alu_ready && (alu_reg != '0);
    assign push_b_c = mem_valid && mem_ready && (mem_reg != '0);
    assign pop_c    = (count != '0) && !flush;

    assign entry_a = '{wreg: alu_reg, data: alu_data};
    assign entry_b = '{wreg: mem_reg, data: mem_data};

    regfile_writeback_queue_wb_fifo u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .push_a      (push_a_c),
        .entry_a     (entry_a),
        .push_b      (push_b_c),
        .entry_b     (entry_b),
        .pop         (pop_c),
        .rs1         (rs1),
        .rs2         (rs2),
        .head_c      (head_c),
        .count       (count),
        .rs1_match_c (rs1_match_c),
        .rs2_match_c (rs2_match_c)
    );

    // Issue register; address/data hold when no write is issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_regwrite <= 1'b0;
            wb_reg      <= '0;
            wb_data     <= '0;
        end else if (pop_c) begin
            wb_regwrite <= 1'b1;
            wb_reg      <= head_c.wreg;
            wb_data     <= head_c.data;
        end else begin
            wb_regwrite <= 1'b0;
        end
    end

    assign rs1_pending = (rs1 != '0) &&
                         ((|rs1_match_c) || (wb_regwrite && (wb_reg == rs1)));
    assign rs2_pending = (rs2 != '0) &&
                         ((|rs2_match_c) || (wb_regwrite && (wb_reg == rs2)));

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Directed self-checking bench for regfile_writeback_queue.
module tb_regfile_writeback_queue;

    logic        clk;
    logic        rst_n;
    logic        alu_valid;
    logic [3:0]  alu_reg;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        mem_valid;
    logic [3:0]  mem_reg;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic        flush;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic        rs1_pending;
    logic        rs2_pending;
    logic        wb_regwrite;
    logic [3:0]  wb_reg;
    logic [31:0] wb_data;

    int n_assert = 0;
    int n_fail   = 0;

    regfile_writeback_queue dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .alu_valid   (alu_valid),
        .alu_reg     (alu_reg),
        .alu_data    (alu_data),
        .alu_ready   (alu_ready),
        .mem_valid   (mem_valid),
        .mem_reg     (mem_reg),
        .mem_data    (mem_data),
        .mem_ready   (mem_ready),
        .flush       (flush),
        .rs1         (rs1),
        .rs2         (rs2),
        .rs1_pending (rs1_pending),
        .rs2_pending (rs2_pending),
        .wb_regwrite (wb_regwrite),
        .wb_reg      (wb_reg),
        .wb_data     (wb_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic av, input logic [3:0] ar, input logic [31:0] ad,
                         input logic mv, input logic [3:0] mr, input logic [31:0] md);
        alu_valid = av; alu_reg = ar; alu_data = ad;
        mem_valid = mv; mem_reg = mr; mem_data = md;
    endtask

    task automatic expect_wb(input string tag, input logic [3:0] r, input logic [31:0] d);
        check({tag, "_we"},   32'(wb_regwrite), 32'd1);
        check({tag, "_reg"},  32'(wb_reg), 32'(r));
        check({tag, "_data"}, wb_data, d);
    endtask

    initial begin
        clk = 1'b0; rst_n = 1'b0; flush = 1'b0; rs1 = 4'd3; rs2 = 4'd0;
        drive(0, 0, 0, 0, 0, 0);

        // 1: reset values, single ALU push, two-cycle latency
        #12;
        check("rst_we",   32'(wb_regwrite), 32'd0);
        check("rst_reg",  32'(wb_reg), 32'd0);
        check("rst_data", wb_data, 32'd0);
        check("rst_pend", 32'(rs1_pending), 32'd0);
        rst_n = 1'b1;
        drive(1, 4'd3, 32'h0000_00AA, 0, 0, 0);
        #1;
        check("s1_alu_ready", 32'(alu_ready), 32'd1);
        check("s1_pend_offer", 32'(rs1_pending), 32'd0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        check("s1_e1_we",   32'(wb_regwrite), 32'd0);
        check("s1_e1_pend", 32'(rs1_pending), 32'd1);
        tick();
        expect_wb("s1_e2", 4'd3, 32'hAA);
        check("s1_e2_pend", 32'(rs1_pending), 32'd1);
        tick();
        check("s1_e3_we",   32'(wb_regwrite), 32'd0);
        check("s1_e3_hold", 32'(wb_reg), 32'd3);
        check("s1_e3_pend", 32'(rs1_pending), 32'd0);

        // 2: dual push, ALU entry issues first
        drive(1, 4'd5, 32'h11, 1, 4'd6, 32'h22);
        rs1 = 4'd5; rs2 = 4'd6;
        #1;
        check("s2_alu_ready", 32'(alu_ready), 32'd1);
        check("s2_mem_ready", 32'(mem_ready), 32'd1);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        check("s2_pend1", 32'(rs1_pending), 32'd1);
        check("s2_pend2", 32'(rs2_pending), 32'd1);
        tick();
        expect_wb("s2_first", 4'd5, 32'h11);
        tick();
        expect_wb("s2_second", 4'd6, 32'h22);
        tick();
        check("s2_idle", 32'(wb_regwrite), 32'd0);

        // 3: back-pressure once the queue holds three entries
        rs1 = 4'd0; rs2 = 4'd0;
        drive(1, 4'd1, 32'h101, 1, 4'd2, 32'h102);
        tick();
        drive(1, 4'd3, 32'h103, 1, 4'd4, 32'h104);
        #1;
        check("s3_c2_alu_ready", 32'(alu_ready), 32'd1);
        check("s3_c2_mem_ready", 32'(mem_ready), 32'd1);
        tick();
        drive(1, 4'd5, 32'h105, 1, 4'd6, 32'h106);
        #1;
        expect_wb("s3_w1", 4'd1, 32'h101);
        check("s3_c3_alu_ready", 32'(alu_ready), 32'd1);
        check("s3_c3_mem_ready", 32'(mem_ready), 32'd0);
        tick();
        drive(0, 0, 0, 1, 4'd6, 32'h106);
        #1;
        expect_wb("s3_w2", 4'd2, 32'h102);
        check("s3_memonly_ready", 32'(mem_ready), 32'd1);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        expect_wb("s3_w3", 4'd3, 32'h103);
        tick();
        expect_wb("s3_w4", 4'd4, 32'h104);
        tick();
        expect_wb("s3_w5", 4'd5, 32'h105);
        tick();
        expect_wb("s3_w6", 4'd6, 32'h106);
        tick();
        check("s3_drained", 32'(wb_regwrite), 32'd0);

        // 4: r0 dropped while a simultaneous load is kept; same-register order
        drive(1, 4'd0, 32'hFF, 1, 4'd9, 32'h99);
        rs1 = 4'd0; rs2 = 4'd9;
        #1;
        check("s4_alu_ready", 32'(alu_ready), 32'd1);
        check("s4_r0_pend_pre", 32'(rs1_pending), 32'd0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        check("s4_we0", 32'(wb_regwrite), 32'd0);
        check("s4_r0_pend", 32'(rs1_pending), 32'd0);
        check("s4_r9_pend", 32'(rs2_pending), 32'd1);
        tick();
        expect_wb("s4_r9", 4'd9, 32'h99);
        check("s4_r0_pend_wb", 32'(rs1_pending), 32'd0);
        tick();
        check("s4_no_r0_write", 32'(wb_regwrite), 32'd0);
        rs1 = 4'd7;
        drive(1, 4'd7, 32'd1, 0, 0, 0);
        tick();
        drive(1, 4'd7, 32'd2, 0, 0, 0);
        #1;
        check("s4_r7_pend", 32'(rs1_pending), 32'd1);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        expect_wb("s4_r7a", 4'd7, 32'd1);
        tick();
        expect_wb("s4_r7b", 4'd7, 32'd2);
        tick();
        check("s4_r7_idle", 32'(wb_regwrite), 32'd0);
        check("s4_r7_final", wb_data, 32'd2);
        check("s4_r7_clear", 32'(rs1_pending), 32'd0);

        // 5: flush with three entries queued
        drive(1, 4'd1, 32'd1, 1, 4'd2, 32'd2);
        tick();
        drive(1, 4'd3, 32'd3, 1, 4'd4, 32'd4);
        tick();
        flush = 1'b1;
        drive(1, 4'd8, 32'h88, 1, 4'd9, 32'h99);
        rs1 = 4'd2; rs2 = 4'd1;
        #1;
        expect_wb("s5_pre", 4'd1, 32'd1);
        check("s5_alu_ready", 32'(alu_ready), 32'd0);
        check("s5_mem_ready", 32'(mem_ready), 32'd0);
        check("s5_pend_q",  32'(rs1_pending), 32'd1);
        check("s5_pend_wb", 32'(rs2_pending), 32'd1);
        tick();
        flush = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        rs1 = 4'd2; rs2 = 4'd4;
        #1;
        check("s5_we",    32'(wb_regwrite), 32'd0);
        check("s5_hold",  32'(wb_reg), 32'd1);
        check("s5_pend1", 32'(rs1_pending), 32'd0);
        check("s5_pend2", 32'(rs2_pending), 32'd0);
        rs1 = 4'd8; rs2 = 4'd3;
        #1;
        check("s5_nopush", 32'(rs1_pending), 32'd0);
        check("s5_pend3",  32'(rs2_pending), 32'd0);
        tick();
        check("s5_stale1", 32'(wb_regwrite), 32'd0);
        tick();
        check("s5_stale2", 32'(wb_regwrite), 32'd0);

        // 6: asynchronous reset between edges, then fresh push
        drive(1, 4'd10, 32'hA0, 1, 4'd11, 32'hB0);
        rs1 = 4'd10; rs2 = 4'd11;
        tick();
        drive(0, 0, 0, 0, 0, 0);
        tick();
        expect_wb("s6_pre", 4'd10, 32'hA0);
        check("s6_pre_pend", 32'(rs2_pending), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("s6_rst_we",   32'(wb_regwrite), 32'd0);
        check("s6_rst_reg",  32'(wb_reg), 32'd0);
        check("s6_rst_data", wb_data, 32'd0);
        check("s6_rst_pend1", 32'(rs1_pending), 32'd0);
        check("s6_rst_pend2", 32'(rs2_pending), 32'd0);
        #1;
        rst_n = 1'b1;
        tick();
        check("s6_empty_we",   32'(wb_regwrite), 32'd0);
        check("s6_empty_pend", 32'(rs2_pending), 32'd0);
        rs1 = 4'd3;
        drive(1, 4'd3, 32'h0000_00AA, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        check("s6_e1_we",   32'(wb_regwrite), 32'd0);
        check("s6_e1_pend", 32'(rs1_pending), 32'd1);
        tick();
        expect_wb("s6_e2", 4'd3, 32'hAA);
        tick();
        check("s6_e3_we", 32'(wb_regwrite), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
